// File: rtl/flash_writer.sv
// flash_writer: issues JEDEC byte-program and chip-erase bus-write sequences
// to a parallel x8 NOR flash, then polls RY/BY for completion.
// Optional read-back check of programmed bytes: define FLASH_WRITER_VERIFY_EN.
module flash_writer #(
  parameter int          SETUP_CYC   = 2,
  parameter int          WE_PULSE    = 4,
  parameter int          RY_DLY      = 8,
  parameter logic [31:0] TIMEOUT_CYC = 32'd3_000_000_000
) (
  input  logic        Clock_50,
  input  logic        reset_l,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_erase,
  input  logic [22:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [22:0] FL_ADDR,
  inout  wire  [7:0]  FL_DQ,
  output logic        FL_CE_N,
  output logic        FL_OE_N,
  output logic        FL_WE_N,
  output logic        FL_RST_N,
  output logic        FL_WP_N,
  input  logic        FL_RY
);

  localparam int PH_W       = 8;
  localparam int VERIFY_CYC = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_BLANK  = 3'd4,
    S_POLL   = 3'd5,
`ifdef FLASH_WRITER_VERIFY_EN
    S_VERIFY = 3'd6,
`endif
    S_FINISH = 3'd7
  } state_t;

  state_t          state, state_nxt;
  logic [PH_W-1:0] phase_cnt;
  logic [31:0]     tmo_cnt;
  logic [2:0]      seq_idx;
  logic            erase_q;
  logic [22:0]     addr_q;
  logic [7:0]      data_q;
  logic            ry_meta, ry_sync;
  logic            dq_oe;
  logic            accept;
  logic            last_wr;
  logic            tmo_hit;

  // Address of write number idx in the unlock/command sequence
  function automatic logic [22:0] seq_addr(input logic erase, input logic [2:0] idx,
                                           input logic [22:0] addr);
    logic [22:0] a;
    a = 23'hAAA;
    if (!erase && idx == 3'd3) a = addr;
    else if (idx == 3'd1 || idx == 3'd4) a = 23'h555;
    return a;
  endfunction

  // Data byte of write number idx in the unlock/command sequence
  function automatic logic [7:0] seq_data(input logic erase, input logic [2:0] idx,
                                          input logic [7:0] data);
    logic [7:0] d;
    case (idx)
      3'd0:    d = 8'hAA;
      3'd1:    d = 8'h55;
      3'd2:    d = erase ? 8'h80 : 8'hA0;
      3'd3:    d = erase ? 8'hAA : data;
      3'd4:    d = 8'h55;
      default: d = 8'h10;
    endcase
    return d;
  endfunction

  assign accept   = cmd_valid && cmd_ready;
  assign last_wr  = erase_q ? (seq_idx == 3'd5) : (seq_idx == 3'd3);
  assign tmo_hit  = (tmo_cnt == TIMEOUT_CYC - 32'd1);
  assign FL_RST_N = reset_l;
  assign FL_WP_N  = 1'b1;
  assign FL_DQ    = dq_oe ? seq_data(erase_q, seq_idx, data_q) : 8'bz;

  // RY/BY is asynchronous to Clock_50; two flops before any use
  always_ff @(posedge Clock_50 or negedge reset_l) begin
    if (!reset_l) begin
      ry_meta <= 1'b0;
      ry_sync <= 1'b0;
    end else begin
      ry_meta <= FL_RY;
      ry_sync <= ry_meta;
    end
  end

  // State register
  always_ff @(posedge Clock_50 or negedge reset_l) begin
    if (!reset_l) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cmd_valid) state_nxt = S_SETUP;
      S_SETUP:  if (phase_cnt == PH_W'(SETUP_CYC - 1)) state_nxt = S_STROBE;
      S_STROBE: if (phase_cnt == PH_W'(WE_PULSE - 1)) state_nxt = S_HOLD;
      S_HOLD:   state_nxt = last_wr ? S_BLANK : S_SETUP;
      S_BLANK:  if (phase_cnt == PH_W'(RY_DLY - 1)) state_nxt = S_POLL;
      S_POLL: begin
        if (ry_sync) begin
`ifdef FLASH_WRITER_VERIFY_EN
          state_nxt = erase_q ? S_FINISH : S_VERIFY;
`else
          state_nxt = S_FINISH;
`endif
        end else if (tmo_hit) begin
          state_nxt = S_FINISH;
        end
      end
`ifdef FLASH_WRITER_VERIFY_EN
      S_VERIFY: if (phase_cnt == PH_W'(VERIFY_CYC - 1)) state_nxt = S_FINISH;
`endif
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode: strobes, address and bus direction per state
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    FL_CE_N   = 1'b1;
    FL_OE_N   = 1'b1;
    FL_WE_N   = 1'b1;
    FL_ADDR   = 23'd0;
    dq_oe     = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_SETUP, S_HOLD: begin
        FL_CE_N = 1'b0;
        FL_ADDR = seq_addr(erase_q, seq_idx, addr_q);
        dq_oe   = 1'b1;
      end
      S_STROBE: begin
        FL_CE_N = 1'b0;
        FL_WE_N = 1'b0;
        FL_ADDR = seq_addr(erase_q, seq_idx, addr_q);
        dq_oe   = 1'b1;
      end
`ifdef FLASH_WRITER_VERIFY_EN
      S_VERIFY: begin
        FL_CE_N = 1'b0;
        FL_OE_N = 1'b0;
        FL_ADDR = addr_q;
      end
`endif
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  // Phase timer restarts on every state change
  always_ff @(posedge Clock_50 or negedge reset_l) begin
    if (!reset_l)                phase_cnt <= '0;
    else if (state_nxt != state) phase_cnt <= '0;
    else                         phase_cnt <= phase_cnt + 1'b1;
  end

  // Poll timeout counter, only runs while polling
  always_ff @(posedge Clock_50 or negedge reset_l) begin
    if (!reset_l)            tmo_cnt <= '0;
    else if (state == S_POLL) tmo_cnt <= tmo_cnt + 32'd1;
    else                     tmo_cnt <= '0;
  end

  // Command latch, sequence index and sticky error flag
  always_ff @(posedge Clock_50 or negedge reset_l) begin
    if (!reset_l) begin
      erase_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      seq_idx <= '0;
      error   <= 1'b0;
    end else begin
      if (accept) begin
        erase_q <= cmd_erase;
        addr_q  <= cmd_addr;
        data_q  <= cmd_data;
        seq_idx <= '0;
        error   <= 1'b0;
      end
      if (state == S_HOLD) seq_idx <= seq_idx + 3'd1;
      if (state == S_POLL && !ry_sync && tmo_hit) error <= 1'b1;
`ifdef FLASH_WRITER_VERIFY_EN
      if (state == S_VERIFY && phase_cnt == PH_W'(VERIFY_CYC - 1) && FL_DQ != data_q)
        error <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_flash_writer.sv
// Bench for flash_writer: table of commands plus hand sequences for timeout
// and reset abort. A flash model checks every bus write against a queue of
// expected (address, data) pairs pushed when each command is issued.
module tb_flash_writer;

  logic        Clock_50 = 1'b0;
  logic        reset_l;
  logic        cmd_valid, cmd_erase;
  logic        cmd_ready, busy, done, error;
  logic [22:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic [22:0] FL_ADDR;
  wire  [7:0]  FL_DQ;
  logic        FL_CE_N, FL_OE_N, FL_WE_N, FL_RST_N, FL_WP_N;
  logic        fl_ry;
  logic [7:0]  rd_val;

  typedef struct {
    logic        erase;
    logic [22:0] addr;
    logic [7:0]  data;
    int          busy_cyc;
    logic [7:0]  rd_xor;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [22:0] a;
    logic [7:0]  d;
  } wr_t;

  vec_t vecs[$];
  wr_t  exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int ry_busy = 0;
  int busy_left = 0;
  bit ry_hold = 0;
  bit mon_en = 1;

  assign FL_DQ = (!FL_OE_N && !FL_CE_N) ? rd_val : 8'hzz;

  flash_writer #(.TIMEOUT_CYC(32'd1000)) dut (
    .Clock_50(Clock_50), .reset_l(reset_l),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_erase(cmd_erase),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .busy(busy), .done(done), .error(error),
    .FL_ADDR(FL_ADDR), .FL_DQ(FL_DQ),
    .FL_CE_N(FL_CE_N), .FL_OE_N(FL_OE_N), .FL_WE_N(FL_WE_N),
    .FL_RST_N(FL_RST_N), .FL_WP_N(FL_WP_N), .FL_RY(fl_ry)
  );

  always #10 Clock_50 = ~Clock_50;

  initial forever begin
    @(posedge Clock_50);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_seq(input logic erase, input logic [22:0] addr, input logic [7:0] data);
    if (erase) begin
      exp_q.push_back('{23'hAAA, 8'hAA});
      exp_q.push_back('{23'h555, 8'h55});
      exp_q.push_back('{23'hAAA, 8'h80});
      exp_q.push_back('{23'hAAA, 8'hAA});
      exp_q.push_back('{23'h555, 8'h55});
      exp_q.push_back('{23'hAAA, 8'h10});
    end else begin
      exp_q.push_back('{23'hAAA, 8'hAA});
      exp_q.push_back('{23'h555, 8'h55});
      exp_q.push_back('{23'hAAA, 8'hA0});
      exp_q.push_back('{addr, data});
    end
  endtask

  // Flash model: captures each WE pulse, checks width/spacing/content,
  // and goes busy on RY after the final write of a command
  initial begin
    bit          we_prev, fall_seen;
    int          we_width, last_fall;
    logic [22:0] cap_a;
    logic [7:0]  cap_d;
    wr_t         w;
    we_prev = 1; fall_seen = 0; we_width = 0; last_fall = 0;
    forever begin
      @(negedge Clock_50);
      if (busy_left > 0 && !ry_hold) begin
        busy_left--;
        if (busy_left == 0) fl_ry = 1'b1;
      end
      if (mon_en) begin
        if (!FL_WE_N) begin
          if (we_prev) begin
            if (fall_seen) check("write_spacing", cyc - last_fall, 7);
            fall_seen = 1;
            last_fall = cyc;
            we_width  = 0;
          end
          we_width++;
          cap_a = FL_ADDR;
          cap_d = FL_DQ;
        end else if (!we_prev) begin
          check("we_width", we_width, 4);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got %0h/%0h expected no write", cap_a, cap_d);
          end else begin
            w = exp_q.pop_front();
            check("write_addr", cap_a, w.a);
            check("write_data", cap_d, w.d);
            if (exp_q.size() == 0) begin
              last_rise_cyc = cyc;
              fall_seen = 0;
              if (ry_hold || ry_busy > 0) begin
                fl_ry = 1'b0;
                busy_left = ry_busy;
              end
            end
          end
        end
      end
      we_prev = FL_WE_N;
    end
  end

  // Issues one command and waits (bounded) for its done pulse
  task automatic run_cmd(input vec_t v, output int lat);
    int  n;
    bit  seen;
    push_seq(v.erase, v.addr, v.data);
    ry_busy = v.busy_cyc;
    rd_val  = v.data ^ v.rd_xor;
    @(negedge Clock_50);
    cmd_valid = 1; cmd_erase = v.erase; cmd_addr = v.addr; cmd_data = v.data;
    @(negedge Clock_50);
    cmd_valid = 0;
    check("accept_ce_low", FL_CE_N, 0);
    check("busy_after_accept", busy, 1);
    check("ready_low_busy", cmd_ready, 0);
    check("error_cleared", error, 0);
    seen = 0;
    n = 0;
    while (!seen && n < 3000) begin
      @(negedge Clock_50);
      n++;
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    lat = cyc - last_rise_cyc;
    if (!ry_hold) check("done_after_ry", fl_ry, 1);
    check("error_at_done", error, v.exp_err);
    check("writes_all_seen", exp_q.size(), 0);
    @(negedge Clock_50);
    check("done_one_cycle", done, 0);
    check("ready_after_done", cmd_ready, 1);
  endtask

  initial begin
    int   lat;
    int   n;
    vec_t v;
    fl_ry = 1; rd_val = 0;
    cmd_valid = 0; cmd_erase = 0; cmd_addr = 0; cmd_data = 0;
    reset_l = 0;

    vecs.push_back('{1'b0, 23'h000123, 8'h5A, 100, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 23'h000000, 8'h00, 200, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 23'h7FFFFF, 8'hFF, 0,   8'h00, 1'b0});
    vecs.push_back('{1'b0, 23'h400000, 8'h00, 30,  8'h00, 1'b0});
`ifdef FLASH_WRITER_VERIFY_EN
    vecs.push_back('{1'b0, 23'h000456, 8'h3C, 20,  8'h01, 1'b1});
    vecs.push_back('{1'b0, 23'h000456, 8'h3C, 20,  8'h00, 1'b0});
`endif

    repeat (3) @(negedge Clock_50);
    reset_l = 1;
    @(negedge Clock_50);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_strobes", {FL_CE_N, FL_OE_N, FL_WE_N}, 3'b111);
    check("rst_addr", FL_ADDR, 0);
    check("rst_dq_z", FL_DQ === 8'hzz, 1);
    check("rst_fl_rst_n", FL_RST_N, 1);
    check("rst_wp_n", FL_WP_N, 1);

    foreach (vecs[i]) run_cmd(vecs[i], lat);

    // Timeout: RY never returns; done lands on the 1000th poll cycle
    ry_hold = 1;
    v = '{1'b0, 23'h000010, 8'h11, 0, 8'h00, 1'b1};
    run_cmd(v, lat);
    check("timeout_latency", lat, 1 + 8 + 1000);
    ry_hold = 0;
    fl_ry = 1;
    repeat (3) @(negedge Clock_50);
    check("error_sticky", error, 1);
    v = '{1'b0, 23'h000020, 8'h22, 10, 8'h00, 1'b0};
    run_cmd(v, lat);

    // Reset in the middle of a WE pulse
    push_seq(1'b1, 23'd0, 8'd0);
    @(negedge Clock_50);
    cmd_valid = 1; cmd_erase = 1;
    @(negedge Clock_50);
    cmd_valid = 0;
    n = 0;
    while (FL_WE_N && n < 50) begin
      @(negedge Clock_50);
      n++;
    end
    check("reached_strobe", FL_WE_N, 0);
    mon_en = 0;
    #3 reset_l = 0;
    #1;
    check("abort_we_n", FL_WE_N, 1);
    check("abort_rst_n", FL_RST_N, 0);
    check("abort_dq_z", FL_DQ === 8'hzz, 1);
    check("abort_ce_n", FL_CE_N, 1);
    exp_q.delete();
    repeat (2) @(negedge Clock_50);
    reset_l = 1;
    @(negedge Clock_50);
    check("post_abort_ready", cmd_ready, 1);
    check("post_abort_busy", busy, 0);
    check("post_abort_rst_n", FL_RST_N, 1);
    repeat (10) @(negedge Clock_50);
    check("post_abort_idle", {busy, FL_CE_N, FL_WE_N}, 3'b011);
    mon_en = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(20 * 60000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flash_writer.md
# flash_writer

Programs the parallel audio flash (x8 mode) so the playback path can later stream samples from it. Accepts byte-program and chip-erase commands over a valid/ready handshake. Generates the JEDEC unlock/command bus-write sequences on the flash pins, then waits on the flash RY/BY line for completion. Sits between the host/UART loader and the flash pins; it owns the pins only while the playback reader is held in reset.

## Interface
- SETUP_CYC, 2: cycles address/data/CE are stable before WE falls.
- WE_PULSE, 4: cycles FL_WE_N is held low per bus write (80 ns at 50 MHz).
- RY_DLY, 8: blanking cycles after the last bus write before RY/BY is sampled.
- TIMEOUT_CYC, 32'd3_000_000_000: maximum poll cycles before an error is flagged.

- Clock_50  in  1  system clock, 50 MHz
- reset_l  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_erase  in  1  1 = chip erase, 0 = byte program
- cmd_addr  in  23  program address (ignored for erase)
- cmd_data  in  8  program byte (ignored for erase)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when an operation finishes
- error  out  1  sticky: timeout or verify mismatch
- FL_ADDR  out  23  flash address
- FL_DQ  inout  8  flash data, tri-stated when not writing
- FL_CE_N, FL_OE_N, FL_WE_N  out  1 each  flash strobes, active low
- FL_RST_N  out  1  flash reset
- FL_WP_N  out  1  write protect, tied 1
- FL_RY  in  1  flash ready/busy (1 = ready), asynchronous

## Operation
- Reset values: cmd_ready=1, busy=0, done=0, error=0, FL_ADDR=0, FL_CE_N=FL_OE_N=FL_WE_N=1, FL_DQ=Z, FL_WP_N=1. FL_RST_N follows reset_l combinationally, so a reset mid-operation also aborts the flash's embedded algorithm.
- FL_RY passes through a 2-flop synchronizer before any use.
- States: IDLE, SETUP, STROBE, HOLD, BLANK, POLL, VERIFY (macro only), FINISH.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch erase/addr/data, clear error, set seq index 0, go to SETUP.
- Program sequence (4 writes): 0xAAA<-0xAA, 0x555<-0x55, 0xAAA<-0xA0, addr<-data.
- Erase sequence (6 writes): 0xAAA<-0xAA, 0x555<-0x55, 0xAAA<-0x80, 0xAAA<-0xAA, 0x555<-0x55, 0xAAA<-0x10.
- Each bus write runs three phases:
  - SETUP: SETUP_CYC cycles, CE low, WE high, FL_ADDR/FL_DQ driven.
  - STROBE: WE_PULSE cycles, WE low.
  - HOLD: 1 cycle, WE high, address/data still driven.
- After HOLD, advance the index. If it was the last write, go to BLANK; otherwise return to SETUP.
- BLANK: RY_DLY cycles, CE high, DQ released.
- POLL: increment the timeout counter each cycle.
  - Synchronized FL_RY=1: go to FINISH (or VERIFY when the macro is compiled in).
  - Counter reaches TIMEOUT_CYC: set error, go to FINISH.
- FINISH: done=1 for one cycle, return to IDLE.
- busy = (state != IDLE). cmd_ready = (state == IDLE). A command held valid during busy is not accepted until IDLE.
- FL_OE_N stays 1 in every state except VERIFY.

## Timing
- Accept to first CE low: 1 cycle.
- Bus write length = SETUP_CYC+WE_PULSE+1 = 7 cycles at default parameters.
- Program: 28 cycles of writes, then 8 blank cycles, then poll.
- Erase: 42 cycles of writes, then 8 blank cycles, then poll.
- done rises 1 cycle after FINISH is entered. With FL_RY already 1 at the end of BLANK, done arrives 2 (sync) + 1 cycles later.
- Back-to-back commands: the next accept is possible in the cycle after done.
- error stays asserted until the next accepted command.

## Configuration
- FLASH_WRITER_VERIFY_EN defined:
  - Byte programs enter VERIFY after POLL. VERIFY drives CE=OE=0 and FL_ADDR=addr for 4 cycles, then samples FL_DQ.
  - A sample != data sets error, then FINISH. Erase skips VERIFY.
  - Adds 4 cycles to program latency.
- Undefined: VERIFY state absent; POLL goes directly to FINISH.

## Test plan
- Reset deasserted with no command -> cmd_ready=1, all strobes 1, FL_DQ=Z, FL_RST_N=1.
- Program addr 0x000123 data 0x5A, FL_RY model goes 0 then back to 1 after 100 cycles:
  - Four WE pulses of 4 cycles at 0xAAA/AA, 0x555/55, 0xAAA/A0, 0x000123/5A.
  - done pulses once, error=0.
- Chip erase -> six writes in the exact erase order, busy until FL_RY=1, then one done pulse.
- FL_RY held 0 with TIMEOUT_CYC overridden to 1000 -> error=1 and done at poll cycle 1000; next accepted command clears error.
- reset_l pulled low mid-STROBE:
  - FL_WE_N=1, FL_RST_N=0, FL_DQ=Z immediately.
  - After release, block is in IDLE with cmd_ready=1.
- With FLASH_WRITER_VERIFY_EN, program 0x3C while the model returns 0x3D -> error=1. Returning 0x3C instead -> error=0.
